div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter XLEN, default 32, operand/result width.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  divide request from EX stage; sampled only in IDLE.
REQ-005 op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with start.
REQ-006 dividend  input  XLEN  rs1 value; sampled with start.
REQ-007 divisor  input  XLEN  rs2 value; sampled with start.
REQ-008 flush  input  1  pipeline kill; aborts the current operation.
REQ-009 busy  output  1  high while state is CALC.
REQ-010 stall_req  output  1  combinational: (IDLE & start & ~flush) | CALC; holds the pipeline.
REQ-011 result_valid  output  1  one-cycle pulse, high only in DONE.
REQ-012 result  output  XLEN  registered quotient/remainder; holds its value until the next DONE.

Function
REQ-013 FSM states are IDLE, CALC and DONE; the state encoding is internal.
REQ-014 IDLE & start & ~flush, normal case: latch op, operand magnitudes (abs for DIV/REM, raw for DIVU/REMU), sign flags and count=0; go to CALC.
REQ-015 IDLE & start & divisor==0: go to DONE next edge, skipping CALC.
  - DIV/DIVU result = all ones.
  - REM/REMU result = dividend.
REQ-016 IDLE & start & signed op & dividend==0x80000000 & divisor==0xFFFFFFFF: go to DONE next edge, skipping CALC.
  - DIV result = 0x80000000.
  - REM result = 0.
REQ-017 CALC: restoring radix-2, one quotient bit per cycle, MSB first.
  - Shift remainder left, shifting in the next dividend bit.
  - Trial subtract divisor at XLEN+1 bits; keep the difference if it is non-negative.
  - Quotient bit = NOT borrow.
REQ-018 CALC runs exactly XLEN cycles; when count==XLEN-1, go to DONE next edge.
REQ-019 DONE: assert result_valid and apply sign correction.
  - Signed quotient is negated when the operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - Unsigned results are not corrected.
REQ-020 DONE then unconditionally goes to IDLE next edge.
REQ-021 Latency, normal case: start sampled at edge T, result_valid high in the cycle after edge T+XLEN (T+32 for XLEN=32).
REQ-022 Latency, special cases: result_valid high in the cycle after edge T.
REQ-023 start asserted in CALC or DONE is ignored; no queuing.
REQ-024 flush in any state: go to IDLE next edge; result_valid stays low; result is unchanged.
REQ-025 flush has priority over start in the same cycle, and flush in DONE suppresses result_valid that cycle.
REQ-026 Operand inputs may change after start is sampled without affecting the result.
REQ-027 All arithmetic is modulo 2^XLEN; negation is two's complement.

Reset
REQ-028 While rst=1: state=IDLE; busy=0, result_valid=0, result=0; internal counter and registers cleared; takes effect immediately, without waiting for clk.
REQ-029 Reset during CALC abandons the operation with no result_valid pulse; first start after release behaves as from cold.

Verification
REQ-030 DIVU 100/7 -> result_valid exactly 32 cycles after start, result=14; REMU 100/7 -> result=2; busy high for 32 cycles.
REQ-031 DIV 0xFFFFFFF9/2 (-7/2) -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD; REM 7/0xFFFFFFFE -> 1.
REQ-032 DIVU 5/0 -> result_valid 1 cycle after start, result=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM -> 0, both 1-cycle latency.
REQ-033 flush in CALC cycle 10 -> no result_valid, result keeps its prior value, IDLE next cycle; immediate DIVU 9/3 -> 3 with normal latency.
REQ-034 Async rst pulse mid-CALC (between edges) -> busy and result_valid fall to 0 and result to 0 before the next edge; no pulse afterwards.
REQ-035 start held high through a whole operation -> exactly one result_valid per IDLE acceptance; stall_req low in the DONE cycle; back-to-back DIVU 0xFFFFFFFF/1 then REMU 0xFFFFFFFF/0x10 -> 0xFFFFFFFF then 0xF.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : div_seq
//  Purpose  : Sequential restoring radix-2 integer divider for the RV M-ext
//             DIV / DIVU / REM / REMU instructions. One quotient bit per
//             cycle, MSB first; divide-by-zero and signed overflow resolve
//             without iterating.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk           core clock, rising-edge
//    rst           asynchronous active-high reset
//    start         divide request (sampled only in IDLE)
//    op[1:0]       00 DIV, 01 DIVU, 10 REM, 11 REMU (sampled with start)
//    dividend      rs1 operand (sampled with start)
//    divisor       rs2 operand (sampled with start)
//    flush         pipeline kill, aborts any operation in flight
//    busy          high while iterating
//    stall_req     holds the pipeline while a request is accepted/iterating
//    result_valid  single-cycle pulse when result is ready
//    result        registered quotient / remainder
// ============================================================================
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic            flush,
  output logic            busy,
  output logic            stall_req,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int                c_CNT_W = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]    c_ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]    c_MIN   = {1'b1, {(XLEN-1){1'b0}}};

  // --------------------------------------------------------------------------
  // State machine encoding
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [XLEN-1:0]    r_rem;     // partial remainder
  logic [XLEN-1:0]    r_quo;     // dividend bits shift out of the top, quotient bits in at the bottom
  logic [XLEN-1:0]    r_dvsr;    // divisor magnitude
  logic [c_CNT_W-1:0] r_count;   // iteration index
  logic               r_is_rem;  // REM/REMU selects remainder as the result
  logic               r_neg_q;   // quotient must be negated
  logic               r_neg_r;   // remainder must be negated
  logic [XLEN-1:0]    r_result;

  // --------------------------------------------------------------------------
  // Request decode (operands are only meaningful in IDLE)
  // --------------------------------------------------------------------------
  logic            w_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_accept;

  assign w_signed   = ~op[0];
  assign w_a_neg    = w_signed & dividend[XLEN-1];
  assign w_b_neg    = w_signed & divisor[XLEN-1];
  assign w_a_mag    = w_a_neg ? -dividend : dividend;
  assign w_b_mag    = w_b_neg ? -divisor  : divisor;
  assign w_div_zero = (divisor == '0);
  assign w_ovf      = w_signed & (dividend == c_MIN) & (divisor == c_ONES);
  assign w_special  = w_div_zero | w_ovf;
  assign w_accept   = (r_state == S_IDLE) & start & ~flush;

  // Architecturally defined results that need no iteration. Divide-by-zero
  // takes precedence; the overflow case can only occur with a non-zero divisor.
  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = op[1] ? dividend : c_ONES;
    end else begin
      w_special_res = op[1] ? '0 : c_MIN;
    end
  end

  // --------------------------------------------------------------------------
  // Restoring iteration step
  // --------------------------------------------------------------------------
  // The shifted remainder is XLEN+1 bits wide. Since the running remainder is
  // always below the divisor, a successful trial subtraction leaves a value
  // that fits in XLEN bits, so the low XLEN bits of the difference suffice;
  // the borrow of the XLEN+1-bit subtraction is the magnitude comparison.
  logic [XLEN:0]   w_shift;
  logic            w_borrow;
  logic [XLEN-1:0] w_diff;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;

  assign w_shift   = {r_rem, r_quo[XLEN-1]};
  assign w_borrow  = (w_shift < {1'b0, r_dvsr});
  assign w_diff    = w_shift[XLEN-1:0] - r_dvsr;
  assign w_rem_nxt = w_borrow ? w_shift[XLEN-1:0] : w_diff;
  assign w_quo_nxt = {r_quo[XLEN-2:0], ~w_borrow};

  // Sign correction is applied to the final step's outputs so the registered
  // result is already correct in the DONE cycle.
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_calc_res;

  assign w_q_fix    = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fix    = r_neg_r ? -w_rem_nxt : w_rem_nxt;
  assign w_calc_res = r_is_rem ? w_r_fix : w_q_fix;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b0;
    stall_req    = 1'b0;
    result_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        stall_req = start & ~flush;
        if (start && !flush) begin
          w_state_nxt = w_special ? S_DONE : S_CALC;
        end
      end

      S_CALC: begin
        busy      = 1'b1;
        stall_req = 1'b1;
        if (flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_count == c_LAST) begin
          w_state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        // A kill arriving in the result cycle retires nothing.
        result_valid = ~flush;
        w_state_nxt  = S_IDLE;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_count  <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_is_rem <= op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_dvsr   <= w_b_mag;
            r_quo    <= w_a_mag;
            r_rem    <= '0;
            r_count  <= '0;
            if (w_special) begin
              r_result <= w_special_res;
            end
          end
        end

        S_CALC: begin
          if (!flush) begin
            r_rem   <= w_rem_nxt;
            r_quo   <= w_quo_nxt;
            r_count <= r_count + c_CNT_W'(1);
            if (r_count == c_LAST) begin
              r_result <= w_calc_res;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_seq
//  Purpose  : Self-checking bench for div_seq (XLEN = 32): directed vector
//             table, randomized operations against an arithmetic reference
//             model, and hand-written flush / reset / held-start sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

  localparam int XLEN = 32;

  logic            clk;
  logic            rst;
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            busy;
  logic            stall_req;
  logic            result_valid;
  logic [XLEN-1:0] result;

  div_seq #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op           (op),
    .dividend     (dividend),
    .divisor      (divisor),
    .flush        (flush),
    .busy         (busy),
    .stall_req    (stall_req),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, got, exp);
    end
  endtask

  // Reference model: plain SV arithmetic plus the architectural special cases.
  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic               ovf;
    logic [31:0]        r;
    sa  = a;
    sb  = b;
    ovf = (o[0] == 1'b0) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r   = '0;
    if (b == 32'd0) begin
      r = o[1] ? a : 32'hFFFF_FFFF;
    end else if (ovf) begin
      r = o[1] ? 32'd0 : 32'h8000_0000;
    end else begin
      case (o)
        2'd0:    r = sa / sb;
        2'd1:    r = a / b;
        2'd2:    r = sa % sb;
        default: r = a % b;
      endcase
    end
    return r;
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] a,
                                   input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return XLEN;
  endfunction

  // Issues one operation from IDLE (called at posedge+1). lat is the number of
  // edges after the accepting edge before result_valid is seen (-1 = timeout).
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int bcyc);
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    op       = 2'($urandom);
    dividend = $urandom;
    divisor  = $urandom;
    res  = '0;
    lat  = -1;
    bcyc = 0;
    for (int k = 0; k <= XLEN + 8; k++) begin
      if (result_valid) begin
        res = result;
        lat = k;
        break;
      end
      if (busy) bcyc++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] res;
  int          lat;
  int          bcyc;
  int          pulses;
  logic [31:0] last_exp;

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    op       = 2'd0;
    dividend = '0;
    divisor  = '0;
    flush    = 1'b0;

    vecs[0]  = '{2'd1, 32'd100,        32'd7,          32'd14,         32};
    vecs[1]  = '{2'd3, 32'd100,        32'd7,          32'd2,          32};
    vecs[2]  = '{2'd0, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32};
    vecs[3]  = '{2'd2, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32};
    vecs[4]  = '{2'd0, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32};
    vecs[5]  = '{2'd2, 32'd7,          32'hFFFF_FFFE,  32'd1,          32};
    vecs[6]  = '{2'd1, 32'd5,          32'd0,          32'hFFFF_FFFF,  0};
    vecs[7]  = '{2'd3, 32'd5,          32'd0,          32'd5,          0};
    vecs[8]  = '{2'd0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  0};
    vecs[9]  = '{2'd2, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          0};
    vecs[10] = '{2'd0, 32'h8000_0000,  32'd1,          32'h8000_0000,  32};
    vecs[11] = '{2'd1, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32};
    vecs[12] = '{2'd2, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFF9,  0};
    vecs[13] = '{2'd0, 32'd0,          32'd5,          32'd0,          32};

    // Reset state
    #12;
    chk("reset busy",         32'(busy),         32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset result",       result,            32'd0);
    chk("reset stall_req",    32'(stall_req),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat, bcyc);
      chk($sformatf("vec%0d result", i),  res,         vecs[i].exp);
      chk($sformatf("vec%0d latency", i), 32'(lat),    32'(vecs[i].lat));
      chk($sformatf("vec%0d busy cycles", i), 32'(bcyc), 32'(vecs[i].lat));
      chk($sformatf("vec%0d pulse width", i), 32'(result_valid), 32'd0);
      chk($sformatf("vec%0d result hold", i), result,  vecs[i].exp);
    end

    // Randomized operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  o;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;
      o   = 2'($urandom_range(0, 3));
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2:       b = 32'($urandom_range(1, 15));
        3:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_op(o, a, b, res, lat, bcyc);
      chk($sformatf("rand%0d op%0d %08h/%08h result", i, o, a, b), res, model(o, a, b));
      chk($sformatf("rand%0d latency", i), 32'(lat), 32'(model_lat(o, a, b)));
      last_exp = model(o, a, b);
    end

    // Flush in CALC cycle 10: nothing retires, result unchanged
    op = 2'd1; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    chk("flush calc busy before", 32'(busy), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush calc no valid", 32'(result_valid), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush calc idle busy",   32'(busy),         32'd0);
    chk("flush calc idle valid",  32'(result_valid), 32'd0);
    chk("flush calc idle stall",  32'(stall_req),    32'd0);
    chk("flush calc result kept", result,            last_exp);
    do_op(2'd1, 32'd9, 32'd3, res, lat, bcyc);
    chk("post-flush DIVU 9/3",   res,      32'd3);
    chk("post-flush latency",    32'(lat), 32'd32);

    // Flush in DONE suppresses the pulse; flush beats start in IDLE
    op = 2'd1; dividend = 32'd5; divisor = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush done no valid", 32'(result_valid), 32'd0);
    chk("flush done stall",    32'(stall_req),    32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush done then idle", 32'(result_valid), 32'd0);
    op = 2'd1; dividend = 32'd50; divisor = 32'd5; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush+start stall_req", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush+start stays idle", 32'(busy),         32'd0);
    chk("flush+start no valid",   32'(result_valid), 32'd0);

    // Asynchronous reset between edges mid-CALC
    op = 2'd1; dividend = 32'd12345; divisor = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy",   32'(busy),         32'd0);
    chk("async rst valid",  32'(result_valid), 32'd0);
    chk("async rst result", result,            32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      if (result_valid) pulses++;
      @(posedge clk); #1;
    end
    chk("post-rst no pulse",    32'(pulses), 32'd0);
    chk("post-rst result zero", result,      32'd0);
    do_op(2'd0, 32'hFFFF_FFF9, 32'd2, res, lat, bcyc);
    chk("cold DIV -7/2",     res,      32'hFFFF_FFFD);
    chk("cold DIV latency",  32'(lat), 32'd32);

    // start held high through a whole operation: exactly one result
    op = 2'd1; dividend = 32'hFFFF_FFFF; divisor = 32'd1; start = 1'b1;
    pulses = 0;
    for (int k = 0; k <= XLEN + 1; k++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        pulses++;
        chk("held start stall_req in DONE", 32'(stall_req), 32'd0);
        chk("held start DIVU FFFFFFFF/1",   result,         32'hFFFF_FFFF);
      end
    end
    start = 1'b0;
    chk("held start pulse count", 32'(pulses), 32'd1);
    do_op(2'd3, 32'hFFFF_FFFF, 32'h10, res, lat, bcyc);
    chk("b2b REMU FFFFFFFF/10", res,      32'hF);
    chk("b2b REMU latency",     32'(lat), 32'd32);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
